serial_add_sub: RTL and testbench

- Parametrised, multi-cycle adder/subtractor built around one DIGIT_W-bit full-adder slice.
- Computes A+B+c_in or A−B−c_in over WIDTH bits, one digit per clock, with the carry/borrow held in a register.
- Exposes a start/busy/done handshake plus carry, borrow and signed-overflow flags.
- Sits in the arithmetic library as the sequential successor to the single-bit full adder, trading latency for area.

---
 rtl/serial_add_sub.sv | 150 +++++++++++++++
 tb/tb_serial_add_sub.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: one DIGIT_W-bit adder slice reused STEPS
// times, with the carry/borrow carried between digits in a register.
module serial_add_sub #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] s_out,
    output logic             ca_out,
    output logic             ovf_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int STEPS = WIDTH / DIGIT_W;
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (DIGIT_W < 1 || DIGIT_W > WIDTH) begin : g_bad_range
            $error("serial_add_sub: DIGIT_W must be in 1..WIDTH");
        end else if (WIDTH % DIGIT_W != 0) begin : g_bad_div
            $error("serial_add_sub: DIGIT_W must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_capture;
    logic   w_step;
    logic   w_last;

    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_sub;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_s;
    logic             r_ca;
    logic             r_ovf;

    logic [DIGIT_W:0]         w_dsum;
    logic [WIDTH+DIGIT_W-1:0] w_cat;
    logic [WIDTH-1:0]         w_acc_next;

    assign w_last = (r_idx == IDX_W'(STEPS - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_step    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_next    = S_RUN;
                    w_capture = 1'b1;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start_in) begin
                    w_next    = S_RUN;
                    w_capture = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands shift right so the active digit is always the low slice;
    // sum digits enter at the top of r_acc and drift down into place.
    assign w_dsum = {1'b0, r_a[DIGIT_W-1:0]}
                  + {1'b0, r_b[DIGIT_W-1:0]}
                  + {{DIGIT_W{1'b0}}, r_carry};
    assign w_cat      = {w_dsum[DIGIT_W-1:0], r_acc};
    assign w_acc_next = w_cat[WIDTH+DIGIT_W-1:DIGIT_W];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_s     <= '0;
            r_ca    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_capture) begin
            r_idx   <= '0;
            r_a     <= a_in;
            r_b     <= sub_in ? ~b_in : b_in;
            r_acc   <= '0;
            r_carry <= c_in ^ sub_in;
            r_sub   <= sub_in;
            r_a_msb <= a_in[WIDTH-1];
            r_b_msb <= b_in[WIDTH-1] ^ sub_in;
        end else if (w_step) begin
            r_idx   <= r_idx + 1'b1;
            r_a     <= r_a >> DIGIT_W;
            r_b     <= r_b >> DIGIT_W;
            r_acc   <= w_acc_next;
            r_carry <= w_dsum[DIGIT_W];
            if (w_last) begin
                r_s   <= w_acc_next;
                r_ca  <= w_dsum[DIGIT_W] ^ r_sub;
                r_ovf <= (r_a_msb == r_b_msb)
                      && (w_acc_next[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign s_out    = r_s;
    assign ca_out   = r_ca;
    assign ovf_out  = r_ovf;
    assign busy_out = (r_state == S_RUN);
    assign done_out = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: default 16/4 instance plus a
// 1/1 instance acting as a registered full adder.
module tb_serial_add_sub;

    localparam int STEPS0 = 4;
    localparam int STEPS1 = 1;

    typedef struct {
        logic [15:0] s;
        bit          ca;
        bit          ovf;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          checks;
    int          failures;

    logic        start0, sub0, c0;
    logic [15:0] a0, b0;
    logic [15:0] s0;
    logic        ca0, ovf0, busy0, done0;

    logic        start1, sub1, c1;
    logic [0:0]  a1, b1;
    logic [0:0]  s1;
    logic        ca1, ovf1, busy1, done1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] last0;
    logic [0:0]  last1;
    int          bcnt0, bcnt1;

    serial_add_sub #(.WIDTH(16), .DIGIT_W(4)) dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start0),
        .sub_in(sub0), .a_in(a0), .b_in(b0), .c_in(c0),
        .s_out(s0), .ca_out(ca0), .ovf_out(ovf0),
        .busy_out(busy0), .done_out(done0)
    );

    serial_add_sub #(.WIDTH(1), .DIGIT_W(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start1),
        .sub_in(sub1), .a_in(a1), .b_in(b1), .c_in(c1),
        .s_out(s1), .ca_out(ca1), .ovf_out(ovf1),
        .busy_out(busy1), .done_out(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cyc=%0d",
                     name, got, exp, cyc);
        end
    endfunction

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic exp_t model(bit sub, longint a, longint b,
                                   bit c, int w);
        exp_t   e;
        longint cc, m, half, full, sa, sb, r;
        cc   = c;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        full = sub ? (a - b - cc) : (a + b + cc);
        e.s  = 16'(full & m);
        e.ca = sub ? (full < 0) : (((full >> w) & 1) != 0);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        r    = sub ? (sa - sb - cc) : (sa + sb + cc);
        e.ovf = (r >= half) || (r < -half);
        e.cyc = 0;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            chk("rst_s0", s0, 0);
            chk("rst_ca0", ca0, 0);
            chk("rst_ovf0", ovf0, 0);
            chk("rst_busy0", busy0, 0);
            chk("rst_done0", done0, 0);
            last0 = '0;
            bcnt0 = 0;
        end else begin
            if (busy0) bcnt0++;
            if (done0) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_done0 s=%0h at cyc=%0d", s0, cyc);
                end else begin
                    e = q0.pop_front();
                    chk("s0", s0, e.s);
                    chk("ca0", ca0, e.ca);
                    chk("ovf0", ovf0, e.ovf);
                    chk("done_cyc0", cyc, e.cyc);
                    chk("busy_len0", bcnt0, STEPS0);
                    last0 = e.s;
                end
                bcnt0 = 0;
            end else begin
                chk("hold_s0", s0, last0);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            chk("rst_s1", s1, 0);
            chk("rst_ca1", ca1, 0);
            chk("rst_busy1", busy1, 0);
            chk("rst_done1", done1, 0);
            last1 = '0;
            bcnt1 = 0;
        end else begin
            if (busy1) bcnt1++;
            if (done1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_done1 s=%0h at cyc=%0d", s1, cyc);
                end else begin
                    e = q1.pop_front();
                    chk("s1", s1, e.s);
                    chk("ca1", ca1, e.ca);
                    chk("ovf1", ovf1, e.ovf);
                    chk("done_cyc1", cyc, e.cyc);
                    chk("busy_len1", bcnt1, STEPS1);
                    last1 = e.s[0:0];
                end
                bcnt1 = 0;
            end else begin
                chk("hold_s1", s1, last1);
            end
        end
    end

    // Caller sits on a negedge; start is held for exactly one edge.
    task automatic put0(input bit sub, input logic [15:0] a,
                        input logic [15:0] b, input bit c);
        exp_t e;
        start0 = 1'b1;
        sub0   = sub;
        a0     = a;
        b0     = b;
        c0     = c;
        e      = model(sub, a, b, c, 16);
        e.cyc  = cyc + 1 + STEPS0;
        q0.push_back(e);
    endtask

    task automatic issue0(input bit sub, input logic [15:0] a,
                          input logic [15:0] b, input bit c);
        put0(sub, a, b, c);
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait0(input int max);
        int n = 0;
        while (q0.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout0 pending=%0d at cyc=%0d", q0.size(), cyc);
            q0.delete();
        end
    endtask

    task automatic wait1(input int max);
        int n = 0;
        while (q1.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout1 pending=%0d at cyc=%0d", q1.size(), cyc);
            q1.delete();
        end
    endtask

    function automatic logic [15:0] pick();
        unique case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        exp_t e;
        int   n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start0   = 1'b0; sub0 = 1'b0; c0 = 1'b0; a0 = '0; b0 = '0;
        start1   = 1'b0; sub1 = 1'b0; c1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue0(1'b0, 16'h1234, 16'h4321, 1'b0); wait0(20); @(negedge clk);
        issue0(1'b0, 16'hFFFF, 16'h0001, 1'b0); wait0(20); @(negedge clk);
        issue0(1'b0, 16'h7FFF, 16'h0000, 1'b1); wait0(20); @(negedge clk);
        issue0(1'b1, 16'h0005, 16'h0007, 1'b0); wait0(20); @(negedge clk);
        issue0(1'b1, 16'h8000, 16'h0001, 1'b0); wait0(20); @(negedge clk);
        issue0(1'b1, 16'h0000, 16'h0000, 1'b1); wait0(20); @(negedge clk);

        // start held through RUN with changing operands
        put0(1'b0, 16'h1111, 16'h2222, 1'b1);
        repeat (STEPS0) begin
            @(negedge clk);
            sub0 = 1'($urandom_range(0, 1));
            a0   = 16'($urandom);
            b0   = 16'($urandom);
            c0   = 1'($urandom_range(0, 1));
        end
        start0 = 1'b0;
        wait0(20);
        @(negedge clk);

        // back-to-back: second start lands in the DONE cycle
        issue0(1'b0, 16'hABCD, 16'h1357, 1'b0);
        n = 0;
        while (!done0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done0) begin
            checks++;
            failures++;
            $display("FAIL b2b_no_done at cyc=%0d", cyc);
        end
        issue0(1'b1, 16'h0100, 16'h0200, 1'b1);
        wait0(20);
        @(negedge clk);

        // reset during the second RUN cycle aborts the op
        issue0(1'b0, 16'h4444, 16'h5555, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        e = q0.pop_back();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue0(1'b0, 16'h0001, 16'h0001, 1'b0); wait0(20); @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            issue0(1'($urandom_range(0, 1)), pick(), pick(),
                   1'($urandom_range(0, 1)));
            wait0(20);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // 1-bit instance: full-adder truth table
        for (int i = 0; i < 8; i++) begin
            start1 = 1'b1;
            sub1   = 1'b0;
            a1     = 1'((i >> 2) & 1);
            b1     = 1'((i >> 1) & 1);
            c1     = 1'(i & 1);
            e      = model(1'b0, longint'(a1), longint'(b1), c1, 1);
            e.cyc  = cyc + 1 + STEPS1;
            q1.push_back(e);
            @(negedge clk);
            start1 = 1'b0;
            wait1(10);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
